// File: rtl/mem_bus_pkg.sv
// Shared address map, status-bit layout and UART FSM state type for the
// data-side memory bus.
package mem_bus_pkg;

  localparam logic [31:0] TXDATA_ADDR = 32'hFFFF_0000;
  localparam logic [31:0] STATUS_ADDR = 32'hFFFF_0004;
  localparam logic [31:0] CYCLE_ADDR  = 32'hFFFF_0008;
  localparam logic [3:0]  RAM_REGION  = 4'h0;

  localparam int STAT_OVF   = 7;
  localparam int STAT_BUSY  = 6;
  localparam int STAT_EMPTY = 5;
  localparam int STAT_FULL  = 4;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

endpackage

// File: rtl/mem_bus_if.sv
// Pipeline memory-stage port: store enable, address, store data and
// same-cycle load data.
interface mem_bus_if;
  logic        en;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output en, addr, wdata, input rdata);
  modport slave  (input en, addr, wdata, output rdata);
endinterface

// File: rtl/mem_bus_uart_tx.sv
// Buffered 8N1 UART transmitter: byte FIFO with overflow flag, baud divider
// and a frame FSM that pops the next byte on the stop-bit edge.
module uart_tx
  import mem_bus_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int BAUD_DIV   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_byte,
  input  logic       clr_ovf,
  output logic       tx,
  output logic [3:0] count,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       ovf
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int BAUD_W = $clog2(BAUD_DIV);
  localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [3:0]        DEPTH     = 4'(FIFO_DEPTH);

  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  uart_state_t       state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              pop, push_ok, baud_done;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign full      = (count == DEPTH);
  assign empty     = (count == 4'd0);
  assign push_ok   = push && !full;
  assign baud_done = (baud_q == BAUD_LAST);
  assign busy      = (state_q != IDLE);

  // NOTE: storage arrays carry no reset; the pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= push_byte;
  end

  // NOTE: sequential state uses <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 4'd0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)     rd_ptr <= ptr_inc(rd_ptr);
      case ({push_ok, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
      // A push against a full FIFO drops the byte even if a pop frees a slot on this edge.
      if (push && full) ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    tx      = 1'b1;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = fifo_mem[rd_ptr];
          bit_d   = 3'd0;
          state_d = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (baud_done) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      DATA: begin
        tx = shift_q[0];
        if (baud_done) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_d = '0;
          // Chain straight into the next start bit so queued frames are contiguous.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = fifo_mem[rd_ptr];
            bit_d   = 3'd0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/mem_bus.sv
// Data-side memory bus: word RAM plus an MMIO window with a buffered UART
// transmitter and a writable free-running cycle counter.
module mem_bus
  import mem_bus_pkg::*;
#(
  parameter int RAM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 8,
  parameter int BAUD_DIV   = 16
) (
  input  logic    clk,
  input  logic    reset,
  mem_bus_if.slave bus,
  output logic    tx
);

  localparam int IDX_W = $clog2(RAM_WORDS);

  logic [31:0]      ram [RAM_WORDS];
  logic [31:0]      cycle_q;
  logic [IDX_W-1:0] ram_idx;
  logic             sel_ram, sel_txdata, sel_status, sel_cycle;
  logic [3:0]       count;
  logic             full, empty, busy, ovf;
  logic [7:0]       status;
  logic             unused_addr_lsbs;

  assign sel_ram    = (bus.addr[31:28] == RAM_REGION);
  assign sel_txdata = (bus.addr[31:2] == TXDATA_ADDR[31:2]);
  assign sel_status = (bus.addr[31:2] == STATUS_ADDR[31:2]);
  assign sel_cycle  = (bus.addr[31:2] == CYCLE_ADDR[31:2]);
  // Index bits above the RAM depth are ignored, so the RAM aliases across its region.
  assign ram_idx    = bus.addr[IDX_W+1:2];
  assign unused_addr_lsbs = ^bus.addr[1:0];

  uart_tx #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .BAUD_DIV  (BAUD_DIV)
  ) u_uart_tx (
    .clk      (clk),
    .reset    (reset),
    .push     (bus.en && sel_txdata),
    .push_byte(bus.wdata[7:0]),
    .clr_ovf  (bus.en && sel_status),
    .tx       (tx),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .busy     (busy),
    .ovf      (ovf)
  );

  always_ff @(posedge clk) begin
    if (bus.en && sel_ram) ram[ram_idx] <= bus.wdata;
  end

  // A store to CYCLE wins over the increment so software reads back exactly what it wrote.
  always_ff @(posedge clk) begin
    if (reset)                  cycle_q <= 32'd0;
    else if (bus.en && sel_cycle) cycle_q <= bus.wdata;
    else                        cycle_q <= cycle_q + 32'd1;
  end

  always_comb begin
    status             = 8'd0;
    status[STAT_OVF]   = ovf;
    status[STAT_BUSY]  = busy;
    status[STAT_EMPTY] = empty;
    status[STAT_FULL]  = full;
    status[3:0]        = count;
  end

  always_comb begin
    bus.rdata = 32'd0;
    if (sel_ram)         bus.rdata = ram[ram_idx];
    else if (sel_status) bus.rdata = {24'd0, status};
    else if (sel_cycle)  bus.rdata = cycle_q;
  end

endmodule

// File: doc/mem_bus.md
# mem_bus

Data-side memory bus sitting directly downstream of the pipeline's memory stage: it consumes the store enable, address and store data the datapath drives each cycle and returns load data in the same cycle. It decodes the address into a word RAM or a small MMIO window holding a buffered UART transmitter and a cycle counter. This gives programs running on the pipeline working data memory, console output and timing without any change to the datapath.

## Interface
- RAM_WORDS, 1024: data RAM depth in 32-bit words; power of two.
- FIFO_DEPTH, 8: UART TX FIFO entries; 2..15.
- BAUD_DIV, 16: clk cycles per UART bit; ≥ 2.
- clk  input  1  clock.
- reset  input  1  synchronous, active-high.
- en  input  1  store enable for this cycle.
- addr  input  32  byte address, word-aligned; addr[1:0] ignored.
- wdata  input  32  store data.
- rdata  output  32  load data, combinational from addr.
- tx  output  1  UART serial line, idle high.

## Operation
- Address map, decoded on addr[31:2]:
  - addr[31:28] == 0: RAM, word index addr[log2(RAM_WORDS)+1:2]; upper bits alias.
  - 0xFFFF_0000 TXDATA: write pushes wdata[7:0] into the FIFO; reads 0.
  - 0xFFFF_0004 STATUS: read {24'b0, ovf, busy, empty, full, count[3:0]}. Any write clears ovf.
  - 0xFFFF_0008 CYCLE: read the free-running counter; write loads it with wdata.
  - Any other address: reads 0, writes ignored.
- RAM: asynchronous read, write at posedge when en. Contents are not cleared by reset.
- FIFO push on TXDATA write: if count == FIFO_DEPTH before the edge, the byte is dropped and ovf is set. This holds even if a pop occurs on the same edge.
- Simultaneous push and pop on a non-full FIFO: count is unchanged and order is preserved.
- CYCLE increments by 1 every cycle and wraps 0xFFFF_FFFF → 0. A write takes priority over the increment, so the next value read is exactly wdata.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If the FIFO is non-empty, pop into the shift register and go to START.
  - START: tx=0 for BAUD_DIV cycles, then DATA with bit index 0.
  - DATA: tx=shift[0] for BAUD_DIV cycles per bit, LSB first. After 8 bits go to STOP.
  - STOP: tx=1 for BAUD_DIV cycles. Then, if the FIFO is non-empty, pop and go to START with no idle gap; otherwise go to IDLE.
- busy = (state != IDLE).

## Timing
- Reset values: tx=1, state IDLE, FIFO empty (count 0), ovf=0, CYCLE=0, baud counter 0. rdata follows the combinational decode of reset state.
- Load latency is 0 cycles: rdata is valid in the same cycle as addr. A store is visible to reads from the cycle after its edge.
- Push at edge N into an idle, empty unit:
  - edge N+1: FSM pops; tx drives 0 from N+1 onward.
  - Each frame is 10·BAUD_DIV cycles.
  - Back-to-back frames are contiguous.
- STATUS.count reflects FIFO occupancy after the last edge. A byte popped into the shift register no longer counts.
- Reset asserted mid-frame: at the next edge tx=1, state is IDLE and FIFO contents are discarded. No partial frame resumes.

## Structure
- Package mem_bus_pkg holds:
  - Address constants TXDATA_ADDR, STATUS_ADDR, CYCLE_ADDR, RAM region tag.
  - Status bit indices.
  - Enum uart_state_t {IDLE, START, DATA, STOP}.
- Sub-module uart_tx: FIFO, baud counter, FSM and ovf bit. Inputs: push, byte, clr_ovf. Outputs: tx, count, full, empty, busy, ovf.
- The top level owns the RAM array, the CYCLE counter and the read mux.

## Test plan
- RAM store 0xDEADBEEF to 0x40, then load 0x40 and 0x44 → 0xDEADBEEF and untouched value. Alias 0x40 + RAM_WORDS·4 reads 0xDEADBEEF.
- BAUD_DIV=4, push 0xA5 at edge N → tx low on cycles N+1..N+4, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, stop high, idle from N+41. STATUS.busy=0 after.
- Push 0x01 then 0x02 on consecutive cycles → two contiguous 40-cycle frames; STATUS.count reads 1 while the first frame is sent.
- Push FIFO_DEPTH+2 bytes back-to-back while idle → first pops and depth fills, last byte dropped, STATUS=ovf|full. Write STATUS → ovf=0.
- Write CYCLE=0xFFFF_FFFE, read the next two cycles → 0xFFFF_FFFE then 0xFFFF_FFFF, then 0x0000_0000 (wrap).
- Assert reset mid-DATA with 3 bytes queued → next cycle tx=1, STATUS=0x20 (empty), and no further frames are sent.
